pipo_bank: RTL and testbench

PIPO_BANK -- requirements
Module: pipo_bank

---
 rtl/pipo_pkg.sv | 9 +
 rtl/pipo_entry.sv | 28 ++
 rtl/pipo_bank.sv | 88 ++++++++
 tb/tb_pipo_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipo_pkg.sv
// Shared constants for the PIPO storage bank.
// Default geometry and the value every entry takes on clear.
package pipo_pkg;

  localparam int   DEF_WIDTH = 16;
  localparam int   DEF_DEPTH = 8;
  localparam logic CLR_BIT   = 1'b0;

endpackage

// File: rtl/pipo_entry.sv
// One storage word: async active-low reset, sync clear, enable, D select.
// Ports: clk, rst, clr, en, sel (1=d_shift, 0=d_load), d_shift, d_load -> q.
module pipo_entry
  import pipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] d_shift,
  input  logic [WIDTH-1:0] d_load,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= {WIDTH{CLR_BIT}};
    end else if (clr) begin
      q <= {WIDTH{CLR_BIT}};
    end else if (en) begin
      q <= sel ? d_shift : d_load;
    end
  end

endmodule

// File: rtl/pipo_bank.sv
// Parallel-in/parallel-out bank with a serial shift path and fill count.
// Ports: clk, rst (async low), Srst, load, shift, waddr, raddr, data_in
//   -> data_out, shift_out, count, full.  Option: PIPO_BANK_BYPASS_EN.
module pipo_bank
  import pipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Srst,
  input  logic             load,
  input  logic             shift,
  input  logic [AW-1:0]    waddr,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] shift_out,
  output logic [AW:0]      count,
  output logic             full
);

  logic [WIDTH-1:0] q [DEPTH];
  logic [WIDTH-1:0] rd_d;

  // Out-of-range waddr never matches any entry index, so it is dropped.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic [WIDTH-1:0] prev;
    logic             en;

    if (k == 0) begin : g_head
      assign prev = data_in;
    end else begin : g_body
      assign prev = q[k-1];
    end

    assign en = shift | (load & (waddr == AW'(k)));

    pipo_entry #(
      .WIDTH(WIDTH)
    ) u_ent (
      .clk    (clk),
      .rst    (rst),
      .clr    (Srst),
      .en     (en),
      .sel    (shift),
      .d_shift(prev),
      .d_load (data_in),
      .q      (q[k])
    );
  end

  always_comb begin
    rd_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (raddr == AW'(k)) rd_d = q[k];
    end
`ifdef PIPO_BANK_BYPASS_EN
    if (shift && raddr == '0) begin
      rd_d = data_in;
    end else if (!shift && load && waddr == raddr &&
                 {1'b0, raddr} < (AW+1)'(DEPTH)) begin
      rd_d = data_in;
    end
`endif
  end

  assign full = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      shift_out <= '0;
      count     <= '0;
    end else if (Srst) begin
      data_out  <= '0;
      shift_out <= '0;
      count     <= '0;
    end else begin
      data_out  <= rd_d;
      shift_out <= q[DEPTH-1];
      if (shift && !full) count <= count + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_pipo_bank.sv
// Self-checking bench for pipo_bank (DEPTH=8, AW=4 so waddr/raddr >= 8 exist).
// Directed vector table, reset corner sequences, then randomized vs model.
module tb_pipo_bank;

  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 4;

`ifdef PIPO_BANK_BYPASS_EN
  localparam logic [W-1:0] EXP37 = 16'h1234;
`else
  localparam logic [W-1:0] EXP37 = 16'h0000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         Srst = 1'b0;
  logic         load = 1'b0;
  logic         shift = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [A-1:0] raddr = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic [W-1:0] shift_out;
  logic [A:0]   count;
  logic         full;

  always #5 clk = ~clk;

  pipo_bank #(
    .WIDTH(W),
    .DEPTH(D),
    .AW   (A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Srst     (Srst),
    .load     (load),
    .shift    (shift),
    .waddr    (waddr),
    .raddr    (raddr),
    .data_in  (data_in),
    .data_out (data_out),
    .shift_out(shift_out),
    .count    (count),
    .full     (full)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural reference: an array of words plus a saturating counter.
  int m_mem [D];
  int m_dout;
  int m_sout;
  int m_cnt;

  function automatic void m_clear();
    for (int k = 0; k < D; k++) m_mem[k] = 0;
    m_dout = 0;
    m_sout = 0;
    m_cnt  = 0;
  endfunction

  function automatic void m_step();
    int ra;
    int wa;
    int nd;
    ra = int'(raddr);
    wa = int'(waddr);
    nd = (ra < D) ? m_mem[ra] : 0;
`ifdef PIPO_BANK_BYPASS_EN
    if (shift && ra == 0) nd = int'(data_in);
    else if (load && wa == ra && wa < D) nd = int'(data_in);
`endif
    if (Srst) begin
      m_clear();
    end else begin
      m_dout = nd;
      m_sout = m_mem[D-1];
      if (shift) begin
        for (int k = D-1; k > 0; k--) m_mem[k] = m_mem[k-1];
        m_mem[0] = int'(data_in);
        if (m_cnt < D) m_cnt++;
      end else if (load && wa < D) begin
        m_mem[wa] = int'(data_in);
      end
    end
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_out"}, int'(data_out), m_dout);
    chk({tag, ".shift_out"}, int'(shift_out), m_sout);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".full"}, int'(full), int'(m_cnt == D));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data_out"}, int'(data_out), 0);
    chk({tag, ".shift_out"}, int'(shift_out), 0);
    chk({tag, ".count"}, int'(count), 0);
    chk({tag, ".full"}, int'(full), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  typedef struct {
    logic         srst;
    logic         ld;
    logic         sh;
    logic [A-1:0] wa;
    logic [A-1:0] ra;
    logic [W-1:0] din;
    logic [W-1:0] e_dout;
    logic [W-1:0] e_sout;
    int           e_cnt;
  } vec_t;

  vec_t vq [$];

  function automatic void add(
    input logic s, input logic l, input logic h,
    input logic [A-1:0] wa, input logic [A-1:0] ra,
    input logic [W-1:0] din, input logic [W-1:0] ed,
    input logic [W-1:0] es, input int ec
  );
    vec_t v;
    v.srst = s; v.ld = l; v.sh = h;
    v.wa = wa; v.ra = ra; v.din = din;
    v.e_dout = ed; v.e_sout = es; v.e_cnt = ec;
    vq.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // fill the bank 1..8 with raddr=7 (still 0 until the 8th edge)
    for (int i = 0; i < D; i++)
      add(0, 0, 1, 0, 7, W'(i + 1), 16'h0, 16'h0, i + 1);
    add(0, 0, 0, 0, 0, 16'h0,    16'h0008, 16'h0001, 8);
    add(0, 0, 1, 0, 7, 16'h0009, 16'h0001, 16'h0001, 8);
    add(0, 0, 0, 0, 7, 16'h0,    16'h0002, 16'h0002, 8);
    add(0, 1, 0, 3, 1, 16'hBEEF, 16'h0008, 16'h0002, 8);
    add(0, 0, 0, 0, 3, 16'h0,    16'hBEEF, 16'h0002, 8);
    add(0, 1, 0, 9, 3, 16'h5555, 16'hBEEF, 16'h0002, 8);
    add(0, 0, 0, 0, 9, 16'h0,    16'h0000, 16'h0002, 8);
    add(0, 0, 0, 0, 3, 16'h0,    16'hBEEF, 16'h0002, 8);
    add(1, 1, 1, 3, 3, 16'hFFFF, 16'h0000, 16'h0000, 0);
    add(0, 0, 0, 0, 3, 16'h0,    16'h0000, 16'h0000, 0);
    add(0, 1, 1, 5, 5, 16'hA5A5, 16'h0000, 16'h0000, 1);
    add(0, 0, 0, 0, 5, 16'h0,    16'h0000, 16'h0000, 1);
    add(0, 0, 0, 0, 0, 16'h0,    16'hA5A5, 16'h0000, 1);
    add(0, 1, 0, 5, 5, 16'h1234, EXP37,    16'h0000, 1);
    add(0, 0, 0, 0, 5, 16'h0,    16'h1234, 16'h0000, 1);

    // reset state
    #1;
    chk_zero("reset");
    m_clear();
    #6;
    rst = 1'b1;

    foreach (vq[i]) begin
      Srst = vq[i].srst; load = vq[i].ld; shift = vq[i].sh;
      waddr = vq[i].wa; raddr = vq[i].ra; data_in = vq[i].din;
      tick();
      chk($sformatf("vec%0d.data_out", i), int'(data_out), int'(vq[i].e_dout));
      chk($sformatf("vec%0d.shift_out", i), int'(shift_out), int'(vq[i].e_sout));
      chk($sformatf("vec%0d.count", i), int'(count), vq[i].e_cnt);
      chk($sformatf("vec%0d.full", i), int'(full), int'(vq[i].e_cnt == D));
    end

    // reset held low with random inputs: everything stays 0
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    m_clear();
    for (int i = 0; i < 4; i++) begin
      Srst = 1'($urandom); load = 1'($urandom); shift = 1'($urandom);
      waddr = A'($urandom); raddr = A'($urandom); data_in = W'($urandom);
      @(posedge clk);
      #1;
      chk_zero($sformatf("rst_held%0d", i));
    end
    Srst = 0; load = 0; shift = 0;
    #2;
    rst = 1'b1;

    // reset pulse between edges during continuous shifting
    shift = 1'b1;
    raddr = 0;
    for (int i = 0; i < 3; i++) begin
      data_in = W'($urandom);
      tick();
      chk_model($sformatf("pre_pulse%0d", i));
    end
    #2;
    rst = 1'b0;
    #1;
    chk_zero("pulse");
    m_clear();
    #1;
    rst = 1'b1;
    data_in = 16'h00C3;
    tick();
    chk("post_pulse.count", int'(count), 1);
    chk_model("post_pulse");
    shift = 1'b0;
    for (int a = 0; a < D; a++) begin
      raddr = A'(a);
      tick();
      chk_model($sformatf("post_pulse_rd%0d", a));
    end

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      Srst = ($urandom_range(0, 31) == 0);
      shift = ($urandom_range(0, 2) == 0);
      load = 1'($urandom);
      waddr = A'($urandom_range(0, 10));
      raddr = A'($urandom_range(0, 10));
      data_in = W'($urandom);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
